// File: rtl/fuzzifier_seq_if.sv
// rtl/fuzzifier_seq_if.sv - operand/result bus between the fuzzifier and its shared trapezoid evaluator
interface fuzzifier_seq_if;
   logic signed [7:0] tz_x;
   logic signed [7:0] tz_a;
   logic signed [7:0] tz_b;
   logic signed [7:0] tz_c;
   logic signed [7:0] tz_d;
   logic [15:0]       tz_mu;

   modport master (
      output tz_x, tz_a, tz_b, tz_c, tz_d,
      input  tz_mu
   );

   modport slave (
      input  tz_x, tz_a, tz_b, tz_c, tz_d,
      output tz_mu
   );
endinterface

// File: rtl/fuzzifier_seq.sv
// rtl/fuzzifier_seq.sv - sequential three-set fuzzifier sharing one trapezoid evaluator
// Optional breakpoint-ordering check enabled by FUZZ_CFG_CHECK_EN.
module fuzzifier_seq #(
   parameter int SETTLE_CYC = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic signed [7:0]  x,
   input  logic signed [7:0]  a_neg,
   input  logic signed [7:0]  b_neg,
   input  logic signed [7:0]  c_neg,
   input  logic signed [7:0]  d_neg,
   input  logic signed [7:0]  a_zero,
   input  logic signed [7:0]  b_zero,
   input  logic signed [7:0]  c_zero,
   input  logic signed [7:0]  d_zero,
   input  logic signed [7:0]  a_pos,
   input  logic signed [7:0]  b_pos,
   input  logic signed [7:0]  c_pos,
   input  logic signed [7:0]  d_pos,
   fuzzifier_seq_if.master    tz,
   output logic               busy,
   output logic               done,
   output logic [15:0]        mu_neg,
   output logic [15:0]        mu_zero,
   output logic [15:0]        mu_pos,
   output logic               cfg_err
);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

   localparam logic [3:0] WAIT_LAST = 4'(SETTLE_CYC - 1);

   state_t            state_q, state_d;
   logic signed [7:0] x_q;
   logic signed [7:0] bp_q  [3][4];
   logic signed [7:0] bp_in [3][4];
   logic [1:0]        sel_q;
   logic [3:0]        wait_q;
   logic [15:0]       shadow_q [3];
   logic [15:0]       mu_q     [3];
   logic              cfg_err_q;
   logic              cfg_bad;
   logic              accept;
   logic              capture;
   logic              last_capture;

   always_comb begin
      bp_in[0][0] = a_neg;  bp_in[0][1] = b_neg;  bp_in[0][2] = c_neg;  bp_in[0][3] = d_neg;
      bp_in[1][0] = a_zero; bp_in[1][1] = b_zero; bp_in[1][2] = c_zero; bp_in[1][3] = d_zero;
      bp_in[2][0] = a_pos;  bp_in[2][1] = b_pos;  bp_in[2][2] = c_pos;  bp_in[2][3] = d_pos;
   end

`ifdef FUZZ_CFG_CHECK_EN
   // Any set with a descending breakpoint pair makes the whole run invalid.
   always_comb begin
      cfg_bad = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if ((bp_in[k][0] > bp_in[k][1]) || (bp_in[k][1] > bp_in[k][2]) ||
             (bp_in[k][2] > bp_in[k][3])) begin
            cfg_bad = 1'b1;
         end
      end
   end
`else
   assign cfg_bad = 1'b0;
`endif

   assign accept       = (state_q == S_IDLE) && start;
   assign capture      = (state_q == S_EVAL) && (wait_q == WAIT_LAST);
   assign last_capture = capture && (sel_q == 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = cfg_bad ? S_DONE : S_EVAL;
         S_EVAL:  if (last_capture) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q != S_IDLE);
      done    = (state_q == S_DONE);
      tz.tz_x = '0;
      tz.tz_a = '0;
      tz.tz_b = '0;
      tz.tz_c = '0;
      tz.tz_d = '0;
      if (state_q == S_EVAL) begin
         tz.tz_x = x_q;
         case (sel_q)
            2'd0: begin
               tz.tz_a = bp_q[0][0]; tz.tz_b = bp_q[0][1]; tz.tz_c = bp_q[0][2]; tz.tz_d = bp_q[0][3];
            end
            2'd1: begin
               tz.tz_a = bp_q[1][0]; tz.tz_b = bp_q[1][1]; tz.tz_c = bp_q[1][2]; tz.tz_d = bp_q[1][3];
            end
            default: begin
               tz.tz_a = bp_q[2][0]; tz.tz_b = bp_q[2][1]; tz.tz_c = bp_q[2][2]; tz.tz_d = bp_q[2][3];
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q       <= '0;
         sel_q     <= '0;
         wait_q    <= '0;
         cfg_err_q <= 1'b0;
         for (int k = 0; k < 3; k++) begin
            shadow_q[k] <= '0;
            mu_q[k]     <= '0;
            for (int j = 0; j < 4; j++) begin
               bp_q[k][j] <= '0;
            end
         end
      end else if (accept) begin
         x_q       <= x;
         sel_q     <= 2'd0;
         wait_q    <= 4'd0;
         cfg_err_q <= cfg_bad;
         for (int k = 0; k < 3; k++) begin
            if (cfg_bad) begin
               mu_q[k] <= '0;
            end
            for (int j = 0; j < 4; j++) begin
               bp_q[k][j] <= bp_in[k][j];
            end
         end
      end else if (state_q == S_EVAL) begin
         if (capture) begin
            case (sel_q)
               2'd0:    shadow_q[0] <= tz.tz_mu;
               2'd1:    shadow_q[1] <= tz.tz_mu;
               default: shadow_q[2] <= tz.tz_mu;
            endcase
            wait_q <= 4'd0;
            sel_q  <= sel_q + 2'd1;
            // The pos result is forwarded straight from the bus since its shadow loads on this same edge.
            if (last_capture) begin
               mu_q[0] <= shadow_q[0];
               mu_q[1] <= shadow_q[1];
               mu_q[2] <= tz.tz_mu;
            end
         end else begin
            wait_q <= wait_q + 4'd1;
         end
      end
   end

   assign mu_neg  = mu_q[0];
   assign mu_zero = mu_q[1];
   assign mu_pos  = mu_q[2];
   assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_fuzzifier_seq.sv
// tb/tb_fuzzifier_seq.sv - bench for fuzzifier_seq with SETTLE_CYC=1 and SETTLE_CYC=3 instances
module tb_fuzzifier_seq;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start1 = 1'b0;
   logic              start3 = 1'b0;
   logic signed [7:0] x = '0;
   logic signed [7:0] bp [3][4];

   logic              busy_w [2];
   logic              done_w [2];
   logic              cfg_w  [2];
   logic [15:0]       mun_w  [2];
   logic [15:0]       muz_w  [2];
   logic [15:0]       mup_w  [2];

   int n_checks = 0;
   int n_errors = 0;

   fuzzifier_seq_if if1 ();
   fuzzifier_seq_if if3 ();

   assign if1.tz_mu = {if1.tz_a, if1.tz_x};
   assign if3.tz_mu = {if3.tz_a, if3.tz_x};

   fuzzifier_seq #(.SETTLE_CYC(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .x(x),
      .a_neg(bp[0][0]), .b_neg(bp[0][1]), .c_neg(bp[0][2]), .d_neg(bp[0][3]),
      .a_zero(bp[1][0]), .b_zero(bp[1][1]), .c_zero(bp[1][2]), .d_zero(bp[1][3]),
      .a_pos(bp[2][0]), .b_pos(bp[2][1]), .c_pos(bp[2][2]), .d_pos(bp[2][3]),
      .tz(if1), .busy(busy_w[0]), .done(done_w[0]),
      .mu_neg(mun_w[0]), .mu_zero(muz_w[0]), .mu_pos(mup_w[0]), .cfg_err(cfg_w[0])
   );

   fuzzifier_seq #(.SETTLE_CYC(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .x(x),
      .a_neg(bp[0][0]), .b_neg(bp[0][1]), .c_neg(bp[0][2]), .d_neg(bp[0][3]),
      .a_zero(bp[1][0]), .b_zero(bp[1][1]), .c_zero(bp[1][2]), .d_zero(bp[1][3]),
      .a_pos(bp[2][0]), .b_pos(bp[2][1]), .c_pos(bp[2][2]), .d_pos(bp[2][3]),
      .tz(if3), .busy(busy_w[1]), .done(done_w[1]),
      .mu_neg(mun_w[1]), .mu_zero(muz_w[1]), .mu_pos(mup_w[1]), .cfg_err(cfg_w[1])
   );

   always #5 clk = ~clk;

   // Model: phase -1 is idle, 0..3S-1 counts evaluation cycles, 3S is the done cycle.
   int                m_ph  [2] = '{-1, -1};
   logic signed [7:0] m_x   [2];
   logic signed [7:0] m_bp  [2][3][4];
   logic [15:0]       m_mu  [2][3];
   logic              m_cfg [2];

   function automatic int sc(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

`ifdef FUZZ_CFG_CHECK_EN
   function automatic bit order_bad();
      bit b = 1'b0;
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < 3; j++)
            if (bp[k][j] > bp[k][j+1]) b = 1'b1;
      return b;
   endfunction
`endif

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_ph[d]  <= -1;
            m_x[d]   <= '0;
            m_cfg[d] <= 1'b0;
            for (int k = 0; k < 3; k++) begin
               m_mu[d][k] <= '0;
               for (int j = 0; j < 4; j++) m_bp[d][k][j] <= '0;
            end
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (m_ph[d] == -1) begin
               if ((d == 0) ? start1 : start3) begin
                  m_x[d] <= x;
                  for (int k = 0; k < 3; k++)
                     for (int j = 0; j < 4; j++) m_bp[d][k][j] <= bp[k][j];
`ifdef FUZZ_CFG_CHECK_EN
                  if (order_bad()) begin
                     m_ph[d]  <= 3 * sc(d);
                     m_cfg[d] <= 1'b1;
                     for (int k = 0; k < 3; k++) m_mu[d][k] <= '0;
                  end else begin
                     m_ph[d]  <= 0;
                     m_cfg[d] <= 1'b0;
                  end
`else
                  m_ph[d] <= 0;
`endif
               end
            end else if (m_ph[d] < 3 * sc(d)) begin
               m_ph[d] <= m_ph[d] + 1;
               if (m_ph[d] + 1 == 3 * sc(d))
                  for (int k = 0; k < 3; k++) m_mu[d][k] <= {m_bp[d][k][0], m_x[d]};
            end else begin
               m_ph[d] <= -1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      for (int d = 0; d < 2; d++) begin
         int p = m_ph[d];
         int s;
         logic [39:0] tz_exp = '0;
         logic [39:0] tz_act;
         if (p >= 0 && p < 3 * sc(d)) begin
            s = p / sc(d);
            tz_exp = {m_x[d], m_bp[d][s][0], m_bp[d][s][1], m_bp[d][s][2], m_bp[d][s][3]};
         end
         tz_act = (d == 0) ? {if1.tz_x, if1.tz_a, if1.tz_b, if1.tz_c, if1.tz_d}
                           : {if3.tz_x, if3.tz_a, if3.tz_b, if3.tz_c, if3.tz_d};
         chk($sformatf("ctl_d%0d", d), {busy_w[d], done_w[d], cfg_w[d]},
             {p >= 0, p == 3 * sc(d), m_cfg[d]});
         chk($sformatf("mu_d%0d", d), {mun_w[d], muz_w[d], mup_w[d]},
             {m_mu[d][0], m_mu[d][1], m_mu[d][2]});
         chk($sformatf("tz_d%0d", d), tz_act, tz_exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
   endtask

   task automatic set_bp_valid();
      bp[0][0] = -100; bp[0][1] = -80; bp[0][2] = -60; bp[0][3] = -40;
      bp[1][0] = -20;  bp[1][1] = -5;  bp[1][2] = 5;   bp[1][3] = 20;
      bp[2][0] = 40;   bp[2][1] = 60;  bp[2][2] = 80;  bp[2][3] = 100;
   endtask

   task automatic run(input int d, output int lat, output int bc);
      if (d == 0) start1 = 1'b1; else start3 = 1'b1;
      tick();
      start1 = 1'b0;
      start3 = 1'b0;
      lat = -1;
      bc  = 0;
      for (int k = 0; k < 40; k++) begin
         if (k > 0) tick();
         if (busy_w[d]) bc++;
         if (done_w[d]) begin
            lat = k;
            break;
         end
      end
      tick();
   endtask

   initial begin
      int lat, bc;
      logic signed [7:0] seq_a [3];
      int last [2];
      int cnt [2];
      logic [47:0] prev [2];
      seq_a[0] = -100; seq_a[1] = -20; seq_a[2] = 40;

      set_bp_valid();
      x = 8'sd5;
      #2 rst_n = 1'b0;
      tick();
      tick();
      chk("reset_busy", busy_w[0], 0);
      chk("reset_mu_neg", mun_w[1], 0);
      rst_n = 1'b1;
      tick();

      // Nominal run, SETTLE_CYC=1
      run(0, lat, bc);
      chk("nom_latency", lat, 3);
      chk("nom_busy_cycles", bc, 4);
      chk("nom_mu_neg", mun_w[0], 16'h9C05);
      chk("nom_mu_zero", muz_w[0], 16'hEC05);
      chk("nom_mu_pos", mup_w[0], 16'h2805);

      // Sequencing, SETTLE_CYC=3
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) tick();
         chk($sformatf("seq_tz_a_%0d", k), if3.tz_a, seq_a[k/3]);
      end
      tick();
      chk("seq_done_at_9", done_w[1], 1);
      tick();

      // Input isolation, plus a start during the done cycle
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      tick();
      x = 8'sd77;
      start3 = 1'b1;
      tick();
      tick();
      start3 = 1'b0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         if (done_w[1]) begin
            lat = k;
            break;
         end
         tick();
      end
      chk("iso_done_seen", lat >= 0, 1);
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      chk("iso_done_start_ignored", busy_w[1], 0);
      chk("iso_mu_neg", mun_w[1], 16'h9C05);
      chk("iso_mu_pos", mup_w[1], 16'h2805);
      tick();
      chk("iso_no_queued_run", busy_w[1], 0);
      x = 8'sd5;

      // Reset in the second evaluation cycle
      start1 = 1'b1;
      start3 = 1'b1;
      tick();
      start1 = 1'b0;
      start3 = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_busy", {busy_w[0], busy_w[1]}, 0);
      chk("rst_mu", {mun_w[0], mup_w[1]}, 0);
      chk("rst_tz", {if1.tz_a, if3.tz_x}, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_no_done", {done_w[0], done_w[1]}, 0);
      end
      rst_n = 1'b1;
      tick();
      run(0, lat, bc);
      chk("post_rst_latency", lat, 3);
      chk("post_rst_mu_pos", mup_w[0], 16'h2805);

      // Misordered zero set
      bp[1][1] = 10;
      bp[1][2] = -10;
      run(0, lat, bc);
`ifdef FUZZ_CFG_CHECK_EN
      chk("cfg_latency", lat, 0);
      chk("cfg_err_set", cfg_w[0], 1);
      chk("cfg_mu_zero", muz_w[0], 0);
`else
      chk("cfg_latency", lat, 3);
      chk("cfg_err_clear", cfg_w[0], 0);
      chk("cfg_mu_zero", muz_w[0], 16'hEC05);
`endif
      set_bp_valid();
      run(0, lat, bc);
      chk("cfg_recover_latency", lat, 3);
      chk("cfg_recover_err", cfg_w[0], 0);

      // Back-to-back with start held high; x varies so every run changes mu
      start1 = 1'b1;
      start3 = 1'b1;
      for (int d = 0; d < 2; d++) begin
         last[d] = -1;
         cnt[d]  = 0;
         prev[d] = {mun_w[d], muz_w[d], mup_w[d]};
      end
      for (int k = 0; k < 40; k++) begin
         tick();
         x = 8'(k + 1);
         for (int d = 0; d < 2; d++) begin
            logic changed;
            changed = ({mun_w[d], muz_w[d], mup_w[d]} != prev[d]);
            chk($sformatf("b2b_mu_only_on_done_d%0d", d), changed && !done_w[d], 0);
            prev[d] = {mun_w[d], muz_w[d], mup_w[d]};
            if (done_w[d]) begin
               if (last[d] >= 0) chk($sformatf("b2b_gap_d%0d", d), k - last[d], (d == 0) ? 5 : 11);
               last[d] = k;
               cnt[d]++;
            end
         end
      end
      chk("b2b_runs_d0", cnt[0], 8);
      chk("b2b_runs_d1", cnt[1], 3);
      start1 = 1'b0;
      start3 = 1'b0;
      for (int k = 0; k < 14; k++) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fuzzifier_seq.md
FUZZIFIER_SEQ -- requirements
Module: fuzzifier_seq

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1, range 1..15: cycles operands are held on the tz_* bus before tz_mu is sampled.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to fuzzify x; accepted only in IDLE.
- x  in  8  signed crisp input.
- a_neg,b_neg,c_neg,d_neg  in  8 each  signed breakpoints, set 0 (neg).
- a_zero,b_zero,c_zero,d_zero  in  8 each  signed breakpoints, set 1 (zero).
- a_pos,b_pos,c_pos,d_pos  in  8 each  signed breakpoints, set 2 (pos).
- tz_x,tz_a,tz_b,tz_c,tz_d  out  8 each  signed operands to the shared trapezoid evaluator.
- tz_mu  in  16  unsigned membership returned by the evaluator.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse; mu_* valid.
- mu_neg,mu_zero,mu_pos  out  16 each  registered membership results.
- cfg_err  out  1  breakpoint-ordering error flag (see Configuration).

Function
REQ-003 SHALL implement the FSM IDLE -> EVAL -> DONE -> IDLE.
REQ-004 In IDLE, start=1 at a rising edge SHALL latch x and all 12 breakpoints, set sel=0, clear the wait counter, and enter EVAL; all later input changes SHALL be ignored until the next accepted start.
REQ-005 In EVAL, tz_x SHALL equal latched x and tz_a..tz_d SHALL equal the latched breakpoints of set sel.
REQ-006 In EVAL, tz_mu SHALL be sampled into shadow register sel at the edge where wait_cnt = SETTLE_CYC-1; that edge SHALL clear wait_cnt and increment sel. Otherwise wait_cnt SHALL increment.
REQ-007 The capture of sel=2 SHALL move the FSM to DONE and copy all three shadows to mu_neg/mu_zero/mu_pos at the same edge. mu_* SHALL change only at this edge.
REQ-008 done SHALL be high for exactly the one DONE cycle; the FSM SHALL then return to IDLE.
REQ-009 Latency from the accepting edge to done high SHALL be exactly 3*SETTLE_CYC cycles.
REQ-010 busy SHALL be high in EVAL and DONE and low in IDLE.
REQ-011 start while busy=1 (including the DONE cycle) SHALL be ignored, with no queuing.
REQ-012 In IDLE and DONE, all tz_* outputs SHALL be 0.
REQ-013 mu_* SHALL hold their values between runs.
REQ-014 tz_mu SHALL be treated as an opaque 16-bit value, with no arithmetic applied.

Reset
REQ-015 When rst_n=0, the block SHALL immediately, without a clock, enter IDLE and clear sel, wait_cnt, the shadows, mu_*, tz_*, busy, done and cfg_err.
REQ-016 Reset during EVAL SHALL abort the run without producing a done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-017 With FUZZ_CFG_CHECK_EN defined, at the accepting edge the block SHALL check a<=b<=c<=d (signed) for each of the three sets.
REQ-018 With FUZZ_CFG_CHECK_EN defined and any set violating the check, the FSM SHALL skip EVAL and enter DONE directly, set mu_*=0, and set cfg_err=1; done then follows one cycle after acceptance.
REQ-019 With FUZZ_CFG_CHECK_EN defined, cfg_err SHALL hold its value until the next accepted start, which SHALL recompute it.
REQ-020 Without FUZZ_CFG_CHECK_EN, cfg_err SHALL be constant 0 and no ordering check SHALL be performed.

Verification
REQ-021 The bench SHALL model the evaluator as tz_mu = {tz_a, tz_x} (8-bit fields), so that operand routing is visible in the results, and SHALL cover:
- Nominal run, SETTLE_CYC=1: x=8'sd5, a_neg=-100, a_zero=-20, a_pos=40, start pulse -> done 3 cycles later; mu_neg=16'h9C05, mu_zero=16'hEC05, mu_pos=16'h2805; busy high 4 cycles.
- Sequencing, SETTLE_CYC=3: tz_a shows the set-0, set-1, set-2 a values for 3 cycles each; done at cycle 9 after acceptance.
- Input isolation: change x to 8'sd77 and start=1 during EVAL -> results still use x=5; no second run; the start in the DONE cycle is ignored.
- Reset mid-run: rst_n=0 at cycle 2 of EVAL -> all outputs 0 immediately, no done; the next start completes normally.
- Ordering check with FUZZ_CFG_CHECK_EN: b_zero=10, c_zero=-10 -> done 1 cycle after acceptance, cfg_err=1, mu_*=0; the next valid start clears cfg_err. Same stimulus without the macro -> normal 3-cycle run, cfg_err=0.
- Back-to-back: start held high continuously -> runs accepted every 3*SETTLE_CYC+2 cycles; mu_* change only on done cycles.
